uart_rx: RTL and testbench

Receive half of the board's 115200-baud 8N1 UART, clocked from the 50 MHz board clock. It recovers bytes from the asynchronous `uart_rxd` pin using a start-bit-aligned, mid-bit sampling state machine. Each received byte is held in a one-entry output register with a ready/acknowledge handshake toward the host logic. It pairs with the existing transmitter, using the same bit timing and the same 8N1 framing.

---
 rtl/uart_rx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Receive half of the 115200-baud 8N1 board UART, clocked from the 50 MHz
// board clock. The asynchronous serial line is synchronized, then a
// start-bit-aligned state machine samples every bit in its middle. Each good
// byte lands in a one-entry holding register with a ready/acknowledge
// handshake toward the host logic.
//
// Ports:
//   clk_50m   in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   uart_rxd  in   asynchronous serial line, idle high
//   rx_ack    in   host consumes the held byte (only honoured while rx_rdy=1)
//   rx_data   out  last good byte
//   rx_rdy    out  rx_data holds an unconsumed byte
//   rx_ferr   out  one-cycle pulse: stop bit sampled low
//   rx_ovr    out  one-cycle pulse: a new byte replaced an unconsumed one
//   rx_busy   out  receiver is somewhere inside a frame
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample is the 2-of-3 majority of
//                        the synchronized line over the sample cycle and the
//                        two cycles before it. Sample timing is unchanged.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int RX_CLKS    = 434,
  parameter int RX_DATA_BW = 8
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic                  uart_rxd,
  input  logic                  rx_ack,
  output logic [RX_DATA_BW-1:0] rx_data,
  output logic                  rx_rdy,
  output logic                  rx_ferr,
  output logic                  rx_ovr,
  output logic                  rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  localparam logic [8:0] HALF_LAST = 9'(RX_CLKS / 2 - 1);
  localparam logic [8:0] BIT_LAST  = 9'(RX_CLKS - 1);
  localparam logic [3:0] IDX_LAST  = 4'(RX_DATA_BW - 1);

  state_e                  state_q, state_d;
  logic                    sync1_q, rxd_s_q;
  logic [8:0]              cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [RX_DATA_BW-1:0]   shift_q, shift_d;
  logic                    load_q, load_d;
  logic                    bad_q, bad_d;
  logic [RX_DATA_BW-1:0]   data_q, data_d;
  logic                    rdy_q, rdy_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;
  logic                    busy_q, busy_d;
  logic                    sample;

`ifdef UART_RX_MAJORITY_EN
  // Two stored cycles plus the current one form the three-sample window.
  logic [1:0] hist_q;
  logic [2:0] win;

  assign win    = {hist_q, rxd_s_q};
  assign sample = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= win[1:0];
    end
  end
`else
  assign sample = rxd_s_q;
`endif

  // Synchronizer flops reset to the idle line level so reset never fakes a
  // start bit; a line that is genuinely low afterwards still starts a frame.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      rxd_s_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      bad_q   <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      bad_q   <= bad_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Frame sequencer. The stop-bit verdict is captured in load/bad and acted
  // on one cycle later, which places the visible update one edge after the
  // stop sample while the FSM is already back in IDLE looking for the next
  // start bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sample) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[RX_DATA_BW-1:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            load_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bad_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break cannot retrigger.
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register and handshake. A load on the same cycle as an ack wins:
  // the byte is fresh, so rdy stays set and no overrun is reported.
  always_comb begin
    data_d = data_q;
    rdy_d  = rdy_q;
    ovr_d  = 1'b0;
    ferr_d = bad_q;
    busy_d = (state_q != IDLE);
    if (load_q) begin
      data_d = shift_q;
      rdy_d  = 1'b1;
      ovr_d  = rdy_q & ~rx_ack;
    end else if (rdy_q && rx_ack) begin
      rdy_d = 1'b0;
    end
  end

  assign rx_data = data_q;
  assign rx_rdy  = rdy_q;
  assign rx_ferr = ferr_q;
  assign rx_ovr  = ovr_q;
  assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Scoreboard bench for uart_rx. The frame driver pushes the expected holding
// register contents and pulse flags, together with the exact cycle they must
// appear on, before driving each frame. A monitor watches the outputs and pops
// an entry whenever the receiver presents something new (byte loaded, overrun
// or framing-error pulse). Edge timing is taken relative to the negedge on
// which the start bit is driven: the following posedge is T0, so an update at
// T0+4126 shows up at the negedge where the cycle counter equals start+4127.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BITC  = 434;
  localparam int FRAME = 10 * BITC;
  localparam int UPD   = 4127;

  typedef struct {
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovr;
    int         cyc;
  } exp_t;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ack  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ferr;
  logic       rx_ovr;
  logic       rx_busy;

  int   cyc = 0;
  int   n_compared = 0;
  int   n_failed = 0;
  exp_t sb_q[$];

  uart_rx dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .uart_rxd(uart_rxd),
    .rx_ack  (rx_ack),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_ferr (rx_ferr),
    .rx_ovr  (rx_ovr),
    .rx_busy (rx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // Drives one 8N1 frame starting at the current negedge. n_steps lets the
  // caller abandon a frame part-way; glitch inverts the line for one cycle so
  // that the synchronized value is wrong exactly at each sample point.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit,
                               input int n_steps, input bit push,
                               input logic exp_ovr, input bit ack_on_load,
                               input bit chk_busy, input bit glitch);
    int   c;
    logic v;
    exp_t e;
    c = cyc;
    if (push) begin
      e.data = stop_bit ? d : rx_data;
      e.rdy  = stop_bit ? 1'b1 : rx_rdy;
      e.ferr = ~stop_bit;
      e.ovr  = exp_ovr;
      e.cyc  = c + UPD;
      sb_q.push_back(e);
    end
    for (int g = 0; g < n_steps; g++) begin
      int k;
      int j;
      k = g / BITC;
      j = g % BITC;
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = stop_bit;
      else             v = d[k-1];
      uart_rxd = (glitch && j == 217) ? ~v : v;
      if (ack_on_load && g == UPD - 1) rx_ack = 1'b1;
      if (ack_on_load && g == UPD)     rx_ack = 1'b0;
      if (chk_busy && g == 3)       checkOutput("busy_before_rise", rx_busy, 0);
      if (chk_busy && g == 4)       checkOutput("busy_rise", rx_busy, 1);
      if (chk_busy && g == UPD - 1) checkOutput("busy_before_fall", rx_busy, 1);
      if (chk_busy && g == UPD)     checkOutput("busy_fall", rx_busy, 0);
      @(negedge clk_50m);
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk_50m);
    rx_ack = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic idle_cycles(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk_50m);
  endtask

  // Monitor: anything the receiver announces must match the head entry.
  logic       prev_rdy  = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk_50m) begin
    if (!rst && (rx_ferr || rx_ovr || (rx_rdy && (!prev_rdy || rx_data != prev_data)))) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_event", 0, 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sb_data", rx_data, e.data);
        checkOutput("sb_rdy",  rx_rdy,  e.rdy);
        checkOutput("sb_ferr", rx_ferr, e.ferr);
        checkOutput("sb_ovr",  rx_ovr,  e.ovr);
        checkOutput("sb_cycle", cyc, e.cyc);
      end
    end
    prev_rdy  <= rx_rdy;
    prev_data <= rx_data;
  end

  initial begin
    repeat (90000) @(posedge clk_50m);
    $display("[TB] FAIL watchdog: got cycle %0d, want completion before 90000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values.
    rst = 1'b1;
    repeat (4) @(negedge clk_50m);
    rst = 1'b0;
    checkOutput("reset_data", rx_data, 0);
    checkOutput("reset_rdy",  rx_rdy,  0);
    checkOutput("reset_ferr", rx_ferr, 0);
    checkOutput("reset_ovr",  rx_ovr,  0);
    checkOutput("reset_busy", rx_busy, 0);
    idle_cycles(10);

    // 0x55, no ack, with busy edge timing.
    applyStimulus(8'h55, 1'b1, FRAME, 1, 1'b0, 0, 1, 0);
    idle_cycles(20);
    checkOutput("hold_55_rdy", rx_rdy, 1);
    pulse_ack();
    checkOutput("ack_clears_rdy", rx_rdy, 0);
    idle_cycles(10);

    // Back-to-back 0xA3 then 0x3C without ack: second one overruns.
    applyStimulus(8'hA3, 1'b1, FRAME, 1, 1'b0, 0, 0, 0);
    applyStimulus(8'h3C, 1'b1, FRAME, 1, 1'b1, 0, 0, 0);
    idle_cycles(20);
    checkOutput("ovr_rdy_kept", rx_rdy, 1);
    pulse_ack();
    idle_cycles(10);

    // 0x7E with a low stop bit, then a long break.
    applyStimulus(8'h7E, 1'b0, FRAME, 1, 1'b0, 0, 0, 0);
    uart_rxd = 1'b0;
    repeat (2000) @(negedge clk_50m);
    checkOutput("break_busy", rx_busy, 1);
    checkOutput("break_rdy", rx_rdy, 0);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk_50m);
    checkOutput("break_released_busy", rx_busy, 0);
    idle_cycles(20);
    applyStimulus(8'h81, 1'b1, FRAME, 1, 1'b0, 0, 0, 0);
    idle_cycles(20);
    pulse_ack();
    idle_cycles(10);

    // 100-clock glitch: receiver gives up at the start sample.
    begin
      int c;
      c = cyc;
      for (int g = 0; g < 300; g++) begin
        uart_rxd = (g < 100) ? 1'b0 : 1'b1;
        if (cyc == c + 220) checkOutput("glitch_busy_hold", rx_busy, 1);
        if (cyc == c + 221) checkOutput("glitch_busy_fall", rx_busy, 0);
        @(negedge clk_50m);
      end
      checkOutput("glitch_rdy", rx_rdy, 0);
    end
    idle_cycles(10);

    // Hold 0x12, then 0xF0 arrives with ack on the exact load cycle.
    applyStimulus(8'h12, 1'b1, FRAME, 1, 1'b0, 0, 0, 0);
    applyStimulus(8'hF0, 1'b1, FRAME, 1, 1'b0, 1, 0, 0);
    idle_cycles(20);
    checkOutput("ack_load_rdy", rx_rdy, 1);
    pulse_ack();
    checkOutput("later_ack_clears", rx_rdy, 0);
    idle_cycles(10);

    // Reset in the middle of data bit 4 of 0xC5, then 0x5A.
    applyStimulus(8'hC5, 1'b1, 5 * BITC + 217, 0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    uart_rxd = 1'b1;
    @(negedge clk_50m);
    rst = 1'b0;
    checkOutput("midreset_data", rx_data, 0);
    checkOutput("midreset_rdy",  rx_rdy,  0);
    checkOutput("midreset_ferr", rx_ferr, 0);
    checkOutput("midreset_ovr",  rx_ovr,  0);
    checkOutput("midreset_busy", rx_busy, 0);
    idle_cycles(20);
    applyStimulus(8'h5A, 1'b1, FRAME, 1, 1'b0, 0, 0, 0);
    idle_cycles(20);

`ifdef UART_RX_MAJORITY_EN
    pulse_ack();
    idle_cycles(10);
    applyStimulus(8'h5A, 1'b1, FRAME, 1, 1'b0, 0, 0, 1);
    idle_cycles(20);
`endif

    idle_cycles(500);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
